wave_sample_streamer: RTL

WAVE_SAMPLE_STREAMER -- requirements
Module: wave_sample_streamer

---
 rtl/wave_pkg.sv | 18 +
 rtl/wave_fifo.sv | 65 ++++++
 rtl/wave_sample_streamer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared types and helpers for the wave sample streamer.
package wave_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Ceiling log2, evaluated at elaboration time for widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wave_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head word is zero when empty.
module wave_fifo
  import wave_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  sample_t                wdata_i,
  output sample_t                rdata_o,
  output logic [clog2(DEPTH):0]  count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = clog2(DEPTH);

  sample_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wave_sample_streamer.sv
// Decimating averager feeding a show-ahead output FIFO with sticky overflow.
// Peak statistics are built only when WAVE_STATS_EN is defined.
module wave_sample_streamer
  import wave_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  sample_in,
  input  logic                        enable,
  input  logic                        clr,
  input  logic                        m_ready,
  output logic                        m_valid,
  output logic [7:0]                  m_data,
  output logic [clog2(FIFO_DEPTH):0]  fill_level,
  output logic                        overflow,
  output logic [7:0]                  peak_max,
  output logic [7:0]                  peak_min
);

  localparam int LOG_D = clog2(DECIM);
  localparam int CNT_W = (LOG_D > 0) ? LOG_D : 1;
  localparam int ACC_W = SAMPLE_W + LOG_D;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum, avg;
  logic             win_last, push, pop, full, empty, drop;
  logic             overflow_q, overflow_d;
  sample_t          push_word;

  // The accumulator is wide enough for DECIM full-scale samples, so sum never wraps.
  assign sum       = acc_q + ACC_W'(sample_in);
  assign avg       = sum >> LOG_D;
  assign push_word = avg[SAMPLE_W-1:0];
  assign win_last  = (cnt_q == CNT_W'(DECIM - 1));
  assign push      = enable && win_last;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (enable) begin
      if (win_last) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum;
      end
    end
  end

  assign pop  = m_valid && m_ready;
  assign drop = push && full && !pop;

  always_comb begin
    overflow_d = overflow_q;
    if (drop)     overflow_d = 1'b1;
    else if (clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  wave_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_word),
    .rdata_o (m_data),
    .count_o (fill_level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign m_valid  = !empty;
  assign overflow = overflow_q;

`ifdef WAVE_STATS_EN
  logic    accept;
  sample_t pmax_q, pmax_d, pmin_q, pmin_d;

  assign accept = push && !drop;

  always_comb begin
    pmax_d = pmax_q;
    pmin_d = pmin_q;
    if (clr) begin
      pmax_d = 8'h00;
      pmin_d = 8'hFF;
    end else if (accept) begin
      if (push_word > pmax_q) pmax_d = push_word;
      if (push_word < pmin_q) pmin_d = push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmax_q <= 8'h00;
      pmin_q <= 8'hFF;
    end else begin
      pmax_q <= pmax_d;
      pmin_q <= pmin_d;
    end
  end

  assign peak_max = pmax_q;
  assign peak_min = pmin_q;
`else
  assign peak_max = 8'h00;
  assign peak_min = 8'hFF;
`endif

endmodule
